// File: rtl/max7219_scheduler.sv
// max7219_scheduler: MAX7219 power-up sequencing, change-only register streaming and periodic full refresh.
module max7219_scheduler #(
    parameter logic [2:0]  SCAN_LIMIT        = 3'd7,
    parameter logic [3:0]  INTENSITY_DEFAULT = 4'h8,
    parameter logic [31:0] REFRESH_PERIOD    = 32'd50_000_000
) (
    input  logic        CLK_IN,
    input  logic        RST,
    input  logic [31:0] data,
    input  logic [7:0]  dot,
    input  logic [3:0]  intensity,
    input  logic        intensity_wr,
    input  logic        blank,
    output logic [15:0] cmd,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        busy,
    output logic        init_done
);
    typedef enum logic [1:0] {INIT, IDLE, SEND} state_t;
    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] cmd_q, cmd_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic [3:0]  int_q, int_d;
    logic        int_dirty_q, int_dirty_d;
    logic        cfg_dirty_q, cfg_dirty_d;
    logic [1:0]  cfg_step_q, cfg_step_d;
    logic        shut_q, shut_d;
    logic [7:0]  dig_q [8];
    logic [7:0]  dig_d [8];
    logic [7:0]  dforce_q, dforce_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  cur [8];
    logic [7:0]  dig_mis;
    logic [2:0]  sel, dsel, dig_idx;
    logic [1:0]  cfg_sel;
    logic [3:0]  addr;
    logic        shut_mis, pend, xfer, wrap;
    logic [15:0] cfg_cmd, shut_cmd, int_cmd, dig_cmd, init_cmd, idle_cmd;
    always_comb begin
        sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cur[i] = {dot[i], 3'b000, data[4*i +: 4]};
            dig_mis[i] = dforce_q[i] | (cur[i] != dig_q[i]);
        end
        for (int i = 7; i >= 0; i--) if (dig_mis[i]) sel = 3'(i);
        shut_mis = (~blank) != shut_q;
        pend = shut_mis | cfg_dirty_q | int_dirty_q | (|dig_mis);
        cfg_sel = (state_q == INIT) ? 2'(idx_q - 4'd1) : cfg_step_q;
        dsel = (state_q == INIT) ? 3'(idx_q - 4'd5) : sel;
        cfg_cmd = (cfg_sel == 2'd0) ? 16'h0F00 : (cfg_sel == 2'd1) ? 16'h09FF : {8'h0B, 5'b0, SCAN_LIMIT};
        shut_cmd = {8'h0C, 7'b0, ~blank};
        int_cmd = {8'h0A, 4'h0, int_q};
        dig_cmd = {4'h0, ({1'b0, dsel} + 4'd1), cur[dsel]};
        init_cmd = (idx_q == 4'd0) ? 16'h0C00 : (idx_q < 4'd4) ? cfg_cmd : (idx_q == 4'd4) ? int_cmd :
                   (idx_q == 4'd13) ? shut_cmd : dig_cmd;
        idle_cmd = shut_mis ? shut_cmd : cfg_dirty_q ? cfg_cmd : int_dirty_q ? int_cmd : dig_cmd;
        xfer = valid_q & cmd_ready;
        addr = cmd_q[11:8];
        dig_idx = cmd_q[10:8] - 3'd1;
        wrap = done_q && (REFRESH_PERIOD != 32'd0) && (cnt_q == REFRESH_PERIOD - 32'd1);
    end
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        cmd_d = cmd_q;
        valid_d = valid_q;
        done_d = done_q;
        int_d = int_q;
        int_dirty_d = int_dirty_q;
        cfg_dirty_d = cfg_dirty_q;
        cfg_step_d = cfg_step_q;
        shut_d = shut_q;
        dig_d = dig_q;
        dforce_d = dforce_q;
        // shadows take the value that actually went out, decoded from the held command
        if (xfer) begin
            valid_d = 1'b0;
            if (addr == 4'hC) shut_d = cmd_q[0];
            if (addr == 4'hA) int_dirty_d = 1'b0;
            if (addr >= 4'd1 && addr <= 4'd8) begin
                dig_d[dig_idx] = cmd_q[7:0];
                dforce_d[dig_idx] = 1'b0;
            end
            if (state_q == SEND && (addr == 4'hF || addr == 4'h9 || addr == 4'hB)) begin
                cfg_step_d = (cfg_step_q == 2'd2) ? 2'd0 : cfg_step_q + 2'd1;
                cfg_dirty_d = cfg_step_q != 2'd2;
            end
        end
        if (state_q == INIT) begin
            if (!valid_q) begin
                cmd_d = init_cmd;
                valid_d = 1'b1;
            end else if (xfer) begin
                idx_d = (idx_q == 4'd13) ? 4'd0 : idx_q + 4'd1;
                done_d = idx_q == 4'd13;
                state_d = (idx_q == 4'd13) ? IDLE : INIT;
            end
        end else if (state_q == IDLE) begin
            if (pend) begin
                cmd_d = idle_cmd;
                valid_d = 1'b1;
                state_d = SEND;
            end
        end else if (xfer) begin
            state_d = IDLE;
        end
        if (intensity_wr) begin
            int_d = intensity;
            int_dirty_d = 1'b1;
        end
        cnt_d = (!done_q || REFRESH_PERIOD == 32'd0 || wrap) ? 32'd0 : cnt_q + 32'd1;
        if (wrap) begin
            cfg_dirty_d = 1'b1;
            int_dirty_d = 1'b1;
            shut_d = blank;
            dforce_d = 8'hFF;
        end
        busy_d = valid_d | pend | (state_d == INIT);
    end
    always_ff @(posedge CLK_IN) begin
        if (!RST) begin
            state_q <= INIT;
            idx_q <= 4'd0;
            cmd_q <= 16'h0000;
            valid_q <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            int_q <= INTENSITY_DEFAULT;
            int_dirty_q <= 1'b0;
            cfg_dirty_q <= 1'b0;
            cfg_step_q <= 2'd0;
            shut_q <= 1'b0;
            dig_q <= '{default: 8'h00};
            dforce_q <= 8'h00;
            cnt_q <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            cmd_q <= cmd_d;
            valid_q <= valid_d;
            done_q <= done_d;
            busy_q <= busy_d;
            int_q <= int_d;
            int_dirty_q <= int_dirty_d;
            cfg_dirty_q <= cfg_dirty_d;
            cfg_step_q <= cfg_step_d;
            shut_q <= shut_d;
            dig_q <= dig_d;
            dforce_q <= dforce_d;
            cnt_q <= cnt_d;
        end
    end
    assign cmd = cmd_q;
    assign cmd_valid = valid_q;
    assign busy = busy_q;
    assign init_done = done_q;
endmodule

// File: tb/tb_max7219_scheduler.sv
// tb_max7219_scheduler: directed vector bench for the MAX7219 command scheduler.
module tb_max7219_scheduler;
    logic        clk, RST, rst_r;
    logic [31:0] data;
    logic [7:0]  dot;
    logic [3:0]  intensity;
    logic        intensity_wr, blank, cmd_ready;
    logic [15:0] cmd, cmd_r;
    logic        cmd_valid, busy, init_done, valid_r, busy_r, done_r;
    int          total, bad, cyc;
    logic [15:0] q [$];
    logic [15:0] qr [$];
    int          qr_t [$];
    typedef struct {
        logic [31:0] data;
        logic [7:0]  dot;
        logic        blank;
        int          n;
        logic [15:0] e0, e1;
    } vec_t;
    vec_t        vt [9];
    logic [15:0] init_exp [14];
    logic [15:0] ref_exp [13];

    max7219_scheduler #(.REFRESH_PERIOD(32'd0)) dut (
        .CLK_IN(clk), .RST(RST), .data(data), .dot(dot), .intensity(intensity),
        .intensity_wr(intensity_wr), .blank(blank), .cmd(cmd), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .busy(busy), .init_done(init_done)
    );
    max7219_scheduler #(.REFRESH_PERIOD(32'd100)) dut_r (
        .CLK_IN(clk), .RST(rst_r), .data(32'h76543210), .dot(8'h01), .intensity(4'h0),
        .intensity_wr(1'b0), .blank(1'b0), .cmd(cmd_r), .cmd_valid(valid_r),
        .cmd_ready(1'b1), .busy(busy_r), .init_done(done_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) if (rst_r) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (RST && cmd_valid && cmd_ready) q.push_back(cmd);
        if (rst_r && valid_r) begin
            qr.push_back(cmd_r);
            qr_t.push_back(cyc + 1);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        RST = 1'b0; rst_r = 1'b0; cmd_ready = 1'b1; blank = 1'b0;
        data = 32'h76543210; dot = 8'h01; intensity = 4'h0; intensity_wr = 1'b0;
        init_exp = '{16'h0C00, 16'h0F00, 16'h09FF, 16'h0B07, 16'h0A08, 16'h0180, 16'h0201,
                     16'h0302, 16'h0403, 16'h0504, 16'h0605, 16'h0706, 16'h0807, 16'h0C01};
        ref_exp = '{16'h0C01, 16'h0F00, 16'h09FF, 16'h0B07, 16'h0A08, 16'h0180, 16'h0201,
                    16'h0302, 16'h0403, 16'h0504, 16'h0605, 16'h0706, 16'h0807};
        vt[0] = '{32'h76943210, 8'h05, 1'b0, 2, 16'h0382, 16'h0609};
        vt[1] = '{32'h76943210, 8'h05, 1'b1, 1, 16'h0C00, 16'h0000};
        vt[2] = '{32'h76943210, 8'h05, 1'b0, 1, 16'h0C01, 16'h0000};
        vt[3] = '{32'hF6943210, 8'h05, 1'b0, 1, 16'h080F, 16'h0000};
        vt[4] = '{32'hF6943210, 8'h85, 1'b0, 1, 16'h088F, 16'h0000};
        vt[5] = '{32'hF6943215, 8'h85, 1'b1, 2, 16'h0C00, 16'h0185};
        vt[6] = '{32'hF6943215, 8'h85, 1'b0, 1, 16'h0C01, 16'h0000};
        vt[7] = '{32'hF6943215, 8'h85, 1'b0, 0, 16'h0000, 16'h0000};
        vt[8] = '{32'h06943205, 8'h05, 1'b0, 2, 16'h0200, 16'h0800};
        repeat (2) tick;
        chk("rst_cmd", cmd, 16'h0000);
        chk("rst_valid", cmd_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", init_done, 1'b0);
        RST = 1'b1; rst_r = 1'b1;
        for (int e = 1; e <= 28; e++) begin
            tick;
            if (e == 1) begin
                chk("first_cmd", cmd, 16'h0C00);
                chk("first_valid", cmd_valid, 1'b1);
            end
            if (e == 27) chk("done_e27", init_done, 1'b0);
            if (e == 28) chk("done_e28", init_done, 1'b1);
        end
        chk("init_len", q.size(), 14);
        for (int i = 0; i < 14 && i < q.size(); i++) chk($sformatf("init_%0d", i), q[i], init_exp[i]);
        repeat (4) tick;
        chk("idle_busy", busy, 1'b0);
        for (int v = 0; v < 9; v++) begin
            data = vt[v].data; dot = vt[v].dot; blank = vt[v].blank;
            q.delete();
            repeat (12) tick;
            chk($sformatf("v%0d_len", v), q.size(), vt[v].n);
            if (vt[v].n > 0 && q.size() > 0) chk($sformatf("v%0d_c0", v), q[0], vt[v].e0);
            if (vt[v].n > 1 && q.size() > 1) chk($sformatf("v%0d_c1", v), q[1], vt[v].e1);
            chk($sformatf("v%0d_busy", v), busy, 1'b0);
        end
        cmd_ready = 1'b0;
        data = 32'h16943205;
        q.delete();
        repeat (2) tick;
        for (int i = 0; i < 10; i++) begin
            if (i == 1 || i == 3) begin
                intensity = (i == 1) ? 4'h3 : 4'hC;
                intensity_wr = 1'b1;
            end
            tick;
            intensity_wr = 1'b0;
            chk($sformatf("hold_cmd_%0d", i), cmd, 16'h0801);
            chk($sformatf("hold_valid_%0d", i), cmd_valid, 1'b1);
        end
        cmd_ready = 1'b1;
        repeat (10) tick;
        chk("int_len", q.size(), 2);
        if (q.size() > 1) begin
            chk("int_c0", q[0], 16'h0801);
            chk("int_c1", q[1], 16'h0A0C);
        end
        chk("int_busy", busy, 1'b0);
        cmd_ready = 1'b0;
        data = 32'h26943205;
        repeat (2) tick;
        chk("pre_rst_cmd", cmd, 16'h0802);
        RST = 1'b0;
        tick;
        chk("mid_rst_valid", cmd_valid, 1'b0);
        chk("mid_rst_done", init_done, 1'b0);
        chk("mid_rst_cmd", cmd, 16'h0000);
        RST = 1'b1; cmd_ready = 1'b1;
        q.delete();
        tick;
        chk("re_first_cmd", cmd, 16'h0C00);
        chk("re_first_valid", cmd_valid, 1'b1);
        repeat (27) tick;
        chk("re_done", init_done, 1'b1);
        chk("re_len", q.size(), 14);
        if (q.size() == 14) begin
            chk("re_c0", q[0], 16'h0C00);
            chk("re_c4", q[4], 16'h0A08);
            chk("re_c12", q[12], 16'h0802);
            chk("re_c13", q[13], 16'h0C01);
        end
        while (cyc < 260) tick;
        chk("ref_len", qr.size() >= 40, 1'b1);
        for (int j = 0; j < 40 && j < qr.size(); j++) begin
            if (j < 14) begin
                chk($sformatf("ref_init_%0d", j), qr[j], init_exp[j]);
                chk($sformatf("ref_init_t%0d", j), qr_t[j], 2 + 2 * j);
            end else begin
                chk($sformatf("ref_%0d", j), qr[j], ref_exp[(j - 14) % 13]);
                chk($sformatf("ref_t%0d", j), qr_t[j], 130 + 100 * ((j - 14) / 13) + 2 * ((j - 14) % 13));
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
